// File: rtl/row_stream_buffer_pkg.sv
// Pixel sensor configuration shared by the sensor datapath blocks.
// Also carries the row stream buffer sequencer state encoding.
package PixelSensorConfig;
    localparam int PIXEL_BITS         = 8;
    localparam int PIXEL_ARRAY_WIDTH  = 8;
    localparam int PIXEL_ARRAY_HEIGHT = 8;
    localparam int OUTPUT_BUS_WIDTH   = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rsb_state_e;
endpackage

// File: rtl/row_stream_buffer_bank_pair.sv
// Two row banks with full flags; reads one LANES-wide beat from a selected bank.
module row_bank_pair
    import PixelSensorConfig::*;
#(
    parameter int WIDTH = PIXEL_ARRAY_WIDTH,
    parameter int LANES = OUTPUT_BUS_WIDTH,
    parameter int BW    = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_wr_en,
    input  logic                              i_wr_sel,
    input  logic [WIDTH-1:0][PIXEL_BITS-1:0]  i_wr_data,
    input  logic                              i_free_en,
    input  logic                              i_free_sel,
    input  logic                              i_rd_sel,
    input  logic [BW-1:0]                     i_rd_beat,
    output logic [1:0]                        o_full,
    output logic [LANES-1:0][PIXEL_BITS-1:0]  o_beat
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0][WIDTH-1:0][PIXEL_BITS-1:0] r_bank;
    logic [1:0]                            r_full;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_bank[i_wr_sel] <= i_wr_data;
    end

    // A write and a free of the same bank in one cycle leaves it full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (i_wr_en && (i_wr_sel == b[0]))
                    r_full[b] <= 1'b1;
                else if (i_free_en && (i_free_sel == b[0]))
                    r_full[b] <= 1'b0;
            end
        end
    end

    always_comb begin
        o_beat = '0;
        for (int l = 0; l < LANES; l++)
            o_beat[l] = r_bank[i_rd_sel][PW'(int'(i_rd_beat) * LANES + l)];
    end

    assign o_full = r_full;
endmodule

// File: rtl/row_stream_buffer.sv
// Ping-pong row buffer: captures whole sensor rows and streams them out
// as LANES-pixel beats under valid/ready, with sticky overflow on dropped rows.
module row_stream_buffer
    import PixelSensorConfig::*;
#(
    parameter int WIDTH = PIXEL_ARRAY_WIDTH,
    parameter int LANES = OUTPUT_BUS_WIDTH,
    parameter int ROWS  = PIXEL_ARRAY_HEIGHT
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              ROW_LOAD,
    input  logic [WIDTH-1:0][PIXEL_BITS-1:0]  DATA_IN,
    input  logic                              CLEAR_OVF,
    input  logic                              OUT_READY,
    output logic                              OUT_VALID,
    output logic [LANES-1:0][PIXEL_BITS-1:0]  DATA_OUT,
    output logic                              OUT_FIRST,
    output logic                              OUT_LAST,
    output logic                              OUT_EOF,
    output logic [$clog2(ROWS)-1:0]           ROW_INDEX,
    output logic                              ROW_FREE,
    output logic                              OVERFLOW
);
    localparam int BEATS = WIDTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RIW   = $clog2(ROWS);

    generate
        if ((WIDTH % LANES) != 0) begin : g_bad_lanes
            $error("row_stream_buffer: WIDTH must be a multiple of LANES");
        end
    endgenerate

    rsb_state_e                      r_state, w_state_nxt;
    logic                            r_rd_bank, w_rd_nxt;
    logic [BW-1:0]                   r_beat;
    logic [RIW-1:0]                  r_row_idx;
    logic                            r_ovf;
    logic [1:0]                      w_full;
    logic [LANES-1:0][PIXEL_BITS-1:0] w_beat_data;
    logic w_valid, w_acc, w_last_beat, w_row_done, w_both_full;
    logic w_load_ok, w_drop, w_wr_sel, w_other;

    assign w_valid     = (r_state == ST_STREAM);
    assign w_acc       = w_valid & OUT_READY;
    assign w_last_beat = (r_beat == BW'(BEATS - 1));
    assign w_row_done  = w_acc & w_last_beat;
    assign w_both_full = &w_full;
    assign w_other     = ~r_rd_bank;
    // Loading while both banks are full is only legal if the streaming bank frees now.
    assign w_load_ok   = ROW_LOAD & (~w_both_full | w_row_done);
    assign w_drop      = ROW_LOAD & ~w_load_ok;

    always_comb begin
        w_wr_sel = 1'b0;
        if (w_both_full)    w_wr_sel = r_rd_bank;
        else if (w_full[0]) w_wr_sel = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_nxt    = r_rd_bank;
        case (r_state)
            ST_IDLE: begin
                if (w_load_ok) begin
                    w_state_nxt = ST_STREAM;
                    w_rd_nxt    = w_wr_sel;
                end
            end
            ST_STREAM: begin
                // Hand over to the other bank with no bubble if it holds, or is receiving, a row.
                if (w_row_done) begin
                    if (w_full[w_other] || (w_load_ok && (w_wr_sel == w_other)))
                        w_rd_nxt = w_other;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_bank <= 1'b0;
            r_beat    <= '0;
            r_row_idx <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_rd_bank <= w_rd_nxt;
            if (w_row_done) begin
                r_beat    <= '0;
                r_row_idx <= (r_row_idx == RIW'(ROWS - 1)) ? '0 : r_row_idx + 1'b1;
            end else if (w_acc) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_drop)         r_ovf <= 1'b1;
            else if (CLEAR_OVF) r_ovf <= 1'b0;
        end
    end

    row_bank_pair #(.WIDTH(WIDTH), .LANES(LANES), .BW(BW)) u_banks (
        .i_clk      (CLK),
        .i_rst_n    (RESET),
        .i_wr_en    (w_load_ok),
        .i_wr_sel   (w_wr_sel),
        .i_wr_data  (DATA_IN),
        .i_free_en  (w_row_done),
        .i_free_sel (r_rd_bank),
        .i_rd_sel   (r_rd_bank),
        .i_rd_beat  (r_beat),
        .o_full     (w_full),
        .o_beat     (w_beat_data)
    );

    assign OUT_VALID = w_valid;
    assign DATA_OUT  = w_valid ? w_beat_data : '0;
    assign OUT_FIRST = w_valid & (r_beat == '0);
    assign OUT_LAST  = w_valid & w_last_beat;
    assign OUT_EOF   = OUT_LAST & (r_row_idx == RIW'(ROWS - 1));
    assign ROW_INDEX = r_row_idx;
    assign ROW_FREE  = ~w_both_full;
    assign OVERFLOW  = r_ovf;
endmodule

// File: tb/tb_row_stream_buffer.sv
// Scoreboard bench for row_stream_buffer at WIDTH=8, LANES=2, ROWS=8.
module tb_row_stream_buffer;
    import PixelSensorConfig::*;

    typedef logic [7:0][7:0] row_t;
    typedef struct packed {
        logic [1:0][7:0] data;
        logic            first;
        logic            last;
        logic            eof;
        logic [2:0]      idx;
    } beat_t;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             ROW_LOAD = 1'b0;
    row_t             DATA_IN = '0;
    logic             CLEAR_OVF = 1'b0;
    logic             OUT_READY = 1'b0;
    logic             OUT_VALID;
    logic [1:0][7:0]  DATA_OUT;
    logic             OUT_FIRST, OUT_LAST, OUT_EOF;
    logic [2:0]       ROW_INDEX;
    logic             ROW_FREE, OVERFLOW;

    row_stream_buffer #(.WIDTH(8), .LANES(2), .ROWS(8)) dut (
        .CLK(CLK), .RESET(RESET), .ROW_LOAD(ROW_LOAD), .DATA_IN(DATA_IN),
        .CLEAR_OVF(CLEAR_OVF), .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
        .DATA_OUT(DATA_OUT), .OUT_FIRST(OUT_FIRST), .OUT_LAST(OUT_LAST),
        .OUT_EOF(OUT_EOF), .ROW_INDEX(ROW_INDEX), .ROW_FREE(ROW_FREE),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    beat_t       q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_idx = 0;
    int          m_push = 0;
    logic        m_ovf = 1'b0;
    logic [24:0] got, exp_v;

    function automatic row_t mkrow(input int base);
        row_t r;
        for (int i = 0; i < 8; i++) r[i] = 8'(base + i);
        return r;
    endfunction

    function automatic logic [24:0] exp_vec();
        logic free;
        free = ((q.size() + 3) / 4) < 2;
        if (q.size() > 0)
            return {1'b1, q[0].data, q[0].first, q[0].last, q[0].eof, q[0].idx, free, m_ovf};
        return {1'b0, 16'h0, 3'b000, 3'(m_idx), free, m_ovf};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {OUT_VALID, DATA_OUT, OUT_FIRST, OUT_LAST, OUT_EOF, ROW_INDEX, ROW_FREE, OVERFLOW};
    endfunction

    task automatic push_row(input row_t r);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.data[0] = r[2*k];
            b.data[1] = r[2*k+1];
            b.first   = (k == 0);
            b.last    = (k == 3);
            b.eof     = (k == 3) && (m_push == 7);
            b.idx     = 3'(m_push);
            q.push_back(b);
        end
        m_push = (m_push + 1) % 8;
    endtask

    // Drive one cycle of inputs, advance the model, and return at the next falling edge.
    task automatic tick(input logic ld, input row_t d, input logic rdy, input logic clr);
        int sz;
        bit acc, lacc, ok;
        ROW_LOAD = ld; DATA_IN = d; OUT_READY = rdy; CLEAR_OVF = clr;
        sz   = q.size();
        acc  = rdy && (sz > 0);
        lacc = acc && ((sz % 4) == 1);
        ok   = ld && ((((sz + 3) / 4) < 2) || lacc);
        if (ld && !ok) m_ovf = 1'b1;
        else if (clr)  m_ovf = 1'b0;
        if (acc) begin
            void'(q.pop_front());
            if (lacc) m_idx = (m_idx + 1) % 8;
        end
        if (ok) push_row(d);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic assert_reset();
        RESET = 1'b0; ROW_LOAD = 1'b0; OUT_READY = 1'b0; CLEAR_OVF = 1'b0; DATA_IN = '0;
        q.delete(); m_idx = 0; m_push = 0; m_ovf = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        for (int c = 0; c < 3; c++) begin
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL reset c%0d: got %h want %h", c, got, exp_v); end
            tick(1'b0, '0, 1'b0, 1'b0);
        end
        RESET = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0);
        got = dut_vec(); exp_v = exp_vec(); n_cmp++;
        if (got !== exp_v) begin n_bad++; $display("FAIL reset_release: got %h want %h", got, exp_v); end
    endtask

    task automatic test_single();
        for (int c = 0; c < 2; c++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL ready_early c%0d: got %h want %h", c, got, exp_v); end
        end
        tick(1'b1, mkrow(0), 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL single c%0d: got %h want %h", c, got, exp_v); end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_stall();
        tick(1'b1, mkrow(8'h10), 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL stall c%0d: got %h want %h", c, got, exp_v); end
            tick(1'b0, '0, (c % 2) == 0, 1'b0);
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, mkrow(8'h20), 1'b0, 1'b0);
        tick(1'b1, mkrow(8'h30), 1'b0, 1'b0);
        tick(1'b1, mkrow(8'h40), 1'b0, 1'b0);
        got = dut_vec(); exp_v = exp_vec(); n_cmp++;
        if (got !== exp_v) begin n_bad++; $display("FAIL overflow_drop: got %h want %h", got, exp_v); end
        tick(1'b1, mkrow(8'h50), 1'b0, 1'b1);
        got = dut_vec(); exp_v = exp_vec(); n_cmp++;
        if (got !== exp_v) begin n_bad++; $display("FAIL overflow_clr_prio: got %h want %h", got, exp_v); end
        tick(1'b0, '0, 1'b0, 1'b1);
        got = dut_vec(); exp_v = exp_vec(); n_cmp++;
        if (got !== exp_v) begin n_bad++; $display("FAIL overflow_clear: got %h want %h", got, exp_v); end
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL overflow_drain c%0d: got %h want %h", c, got, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, mkrow(8'h60), 1'b0, 1'b0);
        tick(1'b1, mkrow(8'h70), 1'b0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL b2b c%0d: got %h want %h", c, got, exp_v); end
            tick(c == 3, mkrow(8'h80), 1'b1, 1'b0);
        end
    endtask

    task automatic test_eof();
        int rows = 0;
        int eofs = 0;
        assert_reset();
        tick(1'b0, '0, 1'b0, 1'b0);
        RESET = 1'b1;
        for (int c = 0; c < 45; c++) begin
            logic ld;
            ld = (rows < 8) && (((q.size() + 3) / 4) < 2);
            tick(ld, mkrow(8'h90 + rows * 8), 1'b1, 1'b0);
            if (ld) rows++;
            if (OUT_EOF === 1'b1) eofs++;
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL eof c%0d: got %h want %h", c, got, exp_v); end
        end
        n_cmp++;
        if (eofs !== 1) begin n_bad++; $display("FAIL eof_count: got %0d want 1", eofs); end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, mkrow(8'hA0), 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL mid_pre c%0d: got %h want %h", c, got, exp_v); end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        assert_reset();
        got = dut_vec(); exp_v = exp_vec(); n_cmp++;
        if (got !== exp_v) begin n_bad++; $display("FAIL mid_reset: got %h want %h", got, exp_v); end
        tick(1'b0, '0, 1'b1, 1'b0);
        RESET = 1'b1;
        tick(1'b0, '0, 1'b1, 1'b0);
        got = dut_vec(); exp_v = exp_vec(); n_cmp++;
        if (got !== exp_v) begin n_bad++; $display("FAIL mid_release: got %h want %h", got, exp_v); end
        tick(1'b1, mkrow(8'hC0), 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            got = dut_vec(); exp_v = exp_vec(); n_cmp++;
            if (got !== exp_v) begin n_bad++; $display("FAIL mid_new c%0d: got %h want %h", c, got, exp_v); end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLK);
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_eof();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
